// File: rtl/ec_datapath_if.sv
// Control/status bundle between the control unit (master) and the
// accumulator datapath (slave), plus the RAM program-load port.
interface ec_datapath_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              IRload;
  logic              JMPmux;
  logic              PCload;
  logic              Meminst;
  logic              MemWr;
  logic [1:0]        Asel;
  logic              Aload;
  logic              Sub;
  logic [DATA_W-1:0] Input;
  logic              ProgEn;
  logic [ADDR_W-1:0] ProgAddr;
  logic [DATA_W-1:0] ProgData;
  logic [DATA_W-1:0] IR;
  logic [DATA_W-1:0] A;
  logic [ADDR_W-1:0] PC;
  logic              Aeq0;
  logic              Apos;

  modport master (
    output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub,
           Input, ProgEn, ProgAddr, ProgData,
    input  IR, A, PC, Aeq0, Apos
  );

  modport slave (
    input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub,
           Input, ProgEn, ProgAddr, ProgData,
    output IR, A, PC, Aeq0, Apos
  );
endinterface

// File: rtl/ec_datapath.sv
// Datapath of the enhanced 8-bit accumulator processor: IR, PC, accumulator,
// add/sub ALU, A-source mux and a synchronous-read RAM with a program port.
module ec_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  ec_datapath_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;

  // Opcode lives in the bits above the address field.
  if (DATA_W != ADDR_W + 3) begin : g_width_chk
    $error("ec_datapath: DATA_W must equal ADDR_W+3");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ir, a, mdata, alu, a_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, addr;

  // Operand fetch uses the IR address field, instruction fetch uses PC.
  assign addr = bus.Meminst ? ir[ADDR_W-1:0] : pc;

  // RAM write port; the program port overrides a datapath store.
  always_ff @(posedge Clock) begin
    if (bus.ProgEn)     mem[bus.ProgAddr] <= bus.ProgData;
    else if (bus.MemWr) mem[addr]         <= a;
  end

  // Registered read; read-during-write returns the word before the write.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) mdata <= '0;
    else        mdata <= mem[addr];
  end

  // Add/subtract, wrapping, no carry out.
  always_comb begin
    alu = bus.Sub ? (a - mdata) : (a + mdata);
  end

  // Accumulator source select.
  always_comb begin
    a_nxt = '0;
    unique case (bus.Asel)
      2'b00:   a_nxt = alu;
      2'b01:   a_nxt = bus.Input;
      2'b10:   a_nxt = mdata;
      default: a_nxt = '0;
    endcase
  end

  // Jump target from IR, otherwise sequential (wraps at the top of memory).
  always_comb begin
    pc_nxt = bus.JMPmux ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
  end

  // Architectural registers; all use pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ir <= '0;
      pc <= '0;
      a  <= '0;
    end else begin
      if (bus.IRload) ir <= mdata;
      if (bus.PCload) pc <= pc_nxt;
      if (bus.Aload)  a  <= a_nxt;
    end
  end

  assign bus.IR   = ir;
  assign bus.A    = a;
  assign bus.PC   = pc;
  assign bus.Aeq0 = (a == '0);
  assign bus.Apos = !a[DATA_W-1] && (a != '0);
endmodule

// File: tb/tb_ec_datapath.sv
// Bench for ec_datapath: directed program from the test plan plus random
// control traffic, all compared against a behavioural model of the machine.
module tb_ec_datapath;
  localparam int DW = 8;
  localparam int AW = 5;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  ec_datapath_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  ec_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  typedef struct packed {
    logic       rst;
    logic       irl;
    logic       jmp;
    logic       pcl;
    logic       mi;
    logic       mw;
    logic [1:0] asel;
    logic       al;
    logic       sub;
    logic [7:0] inp;
    logic       pe;
    logic [4:0] pa;
    logic [7:0] pd;
  } ctl_t;

  int checks = 0;
  int failures = 0;

  // model state
  int m_mem [32];
  int m_ir, m_a, m_pc, m_md;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("IR",   bus.IR,   32'(m_ir));
    chk("A",    bus.A,    32'(m_a));
    chk("PC",   bus.PC,   32'(m_pc));
    chk("Aeq0", bus.Aeq0, 32'(m_a == 0));
    chk("Apos", bus.Apos, 32'(m_a > 0 && m_a < 128));
  endtask

  task automatic model_reset();
    m_ir = 0; m_a = 0; m_pc = 0; m_md = 0;
  endtask

  // One rising edge of the machine, from the rules of the instruction set.
  task automatic model_edge(input ctl_t c);
    int addr, rd, nir, npc, na, alu;
    addr = c.mi ? (m_ir % 32) : m_pc;
    rd   = m_mem[addr];
    if (c.pe)                m_mem[c.pa] = c.pd;
    else if (c.mw && c.rst)  m_mem[addr] = m_a;
    if (!c.rst) begin
      model_reset();
      return;
    end
    alu = c.sub ? (m_a - m_md + 256) % 256 : (m_a + m_md) % 256;
    nir = c.irl ? m_md : m_ir;
    npc = !c.pcl ? m_pc : (c.jmp ? m_ir % 32 : (m_pc + 1) % 32);
    case (c.asel)
      2'd0:    na = alu;
      2'd1:    na = c.inp;
      2'd2:    na = m_md;
      default: na = 0;
    endcase
    if (!c.al) na = m_a;
    m_ir = nir; m_pc = npc; m_a = na; m_md = rd;
  endtask

  task automatic drive(input ctl_t c);
    Reset        = c.rst;
    bus.IRload   = c.irl;
    bus.JMPmux   = c.jmp;
    bus.PCload   = c.pcl;
    bus.Meminst  = c.mi;
    bus.MemWr    = c.mw;
    bus.Asel     = c.asel;
    bus.Aload    = c.al;
    bus.Sub      = c.sub;
    bus.Input    = c.inp;
    bus.ProgEn   = c.pe;
    bus.ProgAddr = c.pa;
    bus.ProgData = c.pd;
  endtask

  // Compare at the falling edge, drive just after, model the rising edge.
  task automatic cyc(input ctl_t c);
    @(negedge Clock);
    compare();
    #1;
    drive(c);
    @(posedge Clock);
    model_edge(c);
    #2;
  endtask

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.rst = 1'b1;
    return c;
  endfunction
  function automatic ctl_t prog(input int ad, input int d, input bit rst = 1'b1);
    ctl_t c = idle();
    c.rst = rst; c.pe = 1'b1; c.pa = 5'(ad); c.pd = 8'(d);
    return c;
  endfunction
  function automatic ctl_t fetch();
    ctl_t c = idle(); c.irl = 1'b1; c.pcl = 1'b1; return c;
  endfunction
  function automatic ctl_t decode();
    ctl_t c = idle(); c.mi = 1'b1; return c;
  endfunction
  function automatic ctl_t aload(input int sel, input bit sub = 1'b0, input int v = 0);
    ctl_t c = idle();
    c.mi = 1'b1; c.al = 1'b1; c.asel = 2'(sel); c.sub = sub; c.inp = 8'(v);
    return c;
  endfunction
  function automatic ctl_t jump(input bit jmp);
    ctl_t c = idle(); c.pcl = 1'b1; c.jmp = jmp; return c;
  endfunction

  initial begin
    ctl_t c;
    c = idle(); c.rst = 1'b0;
    drive(c);
    model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 0;

    // reset state
    #2;
    chk("rst_A", bus.A, 0);
    chk("rst_PC", bus.PC, 0);
    chk("rst_IR", bus.IR, 0);
    chk("rst_Aeq0", bus.Aeq0, 1);
    chk("rst_Apos", bus.Apos, 0);

    // preload the whole RAM while held in reset
    for (int i = 0; i < 32; i++) begin
      int d;
      case (i)
        0: d = 8'h1E; 1: d = 8'h5F; 2: d = 8'h3D; 30: d = 5; 31: d = 7;
        default: d = int'($urandom_range(0, 255));
      endcase
      cyc(prog(i, d, 1'b0));
    end

    // load 30 / add 31 / store 29
    cyc(idle()); cyc(fetch()); cyc(decode()); cyc(aload(2));
    chk("load_A", bus.A, 8'd5);
    cyc(idle()); cyc(fetch()); cyc(decode()); cyc(aload(0));
    chk("add_A", bus.A, 8'd12);
    cyc(idle()); cyc(fetch()); cyc(decode());
    c = decode(); c.mw = 1'b1; cyc(c);
    chk("store_PC", bus.PC, 3);
    chk("store_IR", bus.IR, 8'h3D);
    cyc(aload(3));
    cyc(aload(2));
    chk("M29_readback", bus.A, 8'd12);

    // subtract to zero, then below zero
    cyc(prog(3, 8'h7F)); cyc(prog(31, 12));
    cyc(idle()); cyc(fetch()); cyc(decode()); cyc(aload(0, 1'b1));
    chk("sub0_A", bus.A, 0);
    chk("sub0_Aeq0", bus.Aeq0, 1);
    chk("sub0_Apos", bus.Apos, 0);
    cyc(aload(1, 1'b0, 12));
    cyc(prog(31, 13));
    cyc(decode()); cyc(aload(0, 1'b1));
    chk("subneg_A", bus.A, 8'hFF);
    chk("subneg_Aeq0", bus.Aeq0, 0);
    chk("subneg_Apos", bus.Apos, 0);

    // jumps and PC wrap
    cyc(prog(4, 8'hB4));
    cyc(idle()); cyc(fetch());
    chk("jz_IR", bus.IR, 8'hB4);
    cyc(jump(1'b1));
    chk("jump_PC", bus.PC, 20);
    c = idle(); c.jmp = 1'b1; cyc(c);
    chk("hold_PC", bus.PC, 20);
    cyc(prog(20, 8'hBF));
    cyc(idle()); cyc(fetch()); cyc(jump(1'b1));
    chk("jump31_PC", bus.PC, 31);
    cyc(jump(1'b0));
    chk("wrap_PC", bus.PC, 0);

    // input tracking
    for (int i = 0; i < 3; i++) begin
      cyc(aload(1, 1'b0, 8'h42));
      chk("in42_A", bus.A, 8'h42);
    end
    cyc(aload(1, 1'b0, 8'h10));
    chk("in10_A", bus.A, 8'h10);
    chk("in10_Apos", bus.Apos, 1);

    // read-during-write returns old word; program port beats MemWr
    cyc(aload(1, 1'b0, 8'hAA));
    cyc(prog(31, 8'h11));
    c = decode(); c.mw = 1'b1; cyc(c);
    c = decode(); c.irl = 1'b1; cyc(c);
    chk("rdw_old", bus.IR, 8'h11);
    c = decode(); c.irl = 1'b1; cyc(c);
    chk("rdw_new", bus.IR, 8'hAA);
    c = decode(); c.mw = 1'b1; c.pe = 1'b1; c.pa = 5'd10; c.pd = 8'h5C; cyc(c);
    cyc(decode()); cyc(aload(2));
    chk("prog_wins", bus.A, 8'h5C);

    // asynchronous reset between edges
    cyc(prog(0, 8'h07)); cyc(prog(7, 8'h9C));
    cyc(idle()); cyc(fetch()); cyc(jump(1'b1));
    c = aload(1, 1'b0, 8'h33); c.mi = 1'b0; cyc(c);
    chk("pre_rst_A", bus.A, 8'h33);
    chk("pre_rst_PC", bus.PC, 7);
    @(negedge Clock);
    compare();
    #1;
    c = idle(); c.rst = 1'b0; drive(c);
    #1;
    model_reset();
    chk("arst_A", bus.A, 0);
    chk("arst_PC", bus.PC, 0);
    chk("arst_IR", bus.IR, 0);
    chk("arst_Aeq0", bus.Aeq0, 1);
    #1;
    c = idle(); c.irl = 1'b1; drive(c);
    @(posedge Clock);
    model_edge(c);
    #2;
    chk("arst_Mdata", bus.IR, 0);
    cyc(aload(2));
    chk("arst_ram_kept", bus.A, 8'h07);

    // random control traffic
    for (int n = 0; n < 600; n++) begin
      c = ctl_t'($urandom);
      c.rst = ($urandom_range(0, 40) != 0);
      c.pe  = ($urandom_range(0, 7) == 0);
      if (!c.rst) c.mw = 1'b0;
      cyc(c);
    end

    @(negedge Clock);
    compare();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
